// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, selector geometry and the challenge-to-pair mapping
package puf_pkg;
   typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, HOLD, COMPARE, DONE} state_t;
   localparam int SYNC_LAT = 2;
   localparam int SEL_W = 5;
   localparam int NUM_OSC = 32;
   // XOR term always has bit 0 set, so the two indices can never coincide
   function automatic logic [2*SEL_W-1:0] pair(input logic [7:0] ch, input logic [SEL_W-1:0] i);
      logic [SEL_W-1:0] a;
      a = SEL_W'((32'(ch[4:0]) + 32'(i)) % NUM_OSC);
      return {a, a ^ {ch[7:5], 2'b01}};
   endfunction
endpackage

// File: rtl/puf_phase_timer.sv
// puf_phase_timer: loadable down-counter that times each measurement phase
module puf_phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) value <= '0;
      else if (load) value <= load_val;
      else if (value != '0) value <= value - W'(1);
   assign zero = value == '0;
endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: ring-oscillator PUF evaluation sequencer.
// Define PUF_MAJORITY_VOTE_EN to measure every pair three times and keep the majority.
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int WINDOW_CYCLES = 1024,
   parameter int SETTLE_CYCLES = 4,
   parameter int RESP_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [7:0]           challenge,
   output logic [SEL_W-1:0]     sel_a,
   output logic [SEL_W-1:0]     sel_b,
   output logic                 osc_en,
   output logic                 cnt_clr,
   output logic                 cnt_gate,
   input  logic [CNT_W-1:0]     cnt_a,
   input  logic [CNT_W-1:0]     cnt_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [RESP_BITS-1:0] response,
   output logic                 tie
);
   localparam int TW = $clog2((WINDOW_CYCLES > SETTLE_CYCLES ? WINDOW_CYCLES : SETTLE_CYCLES) + 1);
   localparam int IW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
   state_t state;
   logic [7:0] chal;
   logic [IW-1:0] idx;
   logic [TW-1:0] t_val, t_init;
   logic t_zero, t_load, accept, gt, eq, bit_res, last_round;
   assign accept = req_valid && req_ready;
   assign gt = cnt_a > cnt_b;
   assign eq = cnt_a == cnt_b;
`ifdef PUF_MAJORITY_VOTE_EN
   logic [1:0] round, votes;
   assign last_round = round == 2'd2;
   assign bit_res = (votes + {1'b0, gt}) >= 2'd2;
`else
   assign last_round = 1'b1;
   assign bit_res = gt;
`endif
   assign t_load = (state == IDLE && accept) || (state == SETTLE && t_zero) ||
                   (state == MEASURE && t_zero) || state == COMPARE;
   assign t_init = state == SETTLE  ? TW'(WINDOW_CYCLES - 1) :
                   state == MEASURE ? TW'(SYNC_LAT - 1) : TW'(SETTLE_CYCLES - 1);

   puf_phase_timer #(.W(TW)) u_timer (
      .clk(clk), .rst_n(rst_n), .load(t_load), .load_val(t_init), .value(t_val), .zero(t_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         chal <= '0;
         idx <= '0;
         req_ready <= 1'b1;
         resp_valid <= 1'b0;
         osc_en <= 1'b0;
         cnt_clr <= 1'b0;
         cnt_gate <= 1'b0;
         sel_a <= '0;
         sel_b <= '0;
         response <= '0;
         tie <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
         round <= '0;
         votes <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               state <= SETTLE;
               chal <= challenge;
               idx <= '0;
               response <= '0;
               tie <= 1'b0;
               req_ready <= 1'b0;
               osc_en <= 1'b1;
               cnt_clr <= 1'b1;
               {sel_a, sel_b} <= pair(challenge, '0);
`ifdef PUF_MAJORITY_VOTE_EN
               round <= '0;
               votes <= '0;
`endif
            end
            SETTLE: if (t_zero) begin
               state <= MEASURE;
               cnt_clr <= 1'b0;
               cnt_gate <= 1'b1;
            end
            MEASURE: if (t_zero) begin
               state <= HOLD;
               cnt_gate <= 1'b0;
            end
            // value rather than zero flag: both timer views are equivalent here
            HOLD: if (t_val == '0) state <= COMPARE;
            COMPARE: begin
               tie <= tie | eq;
               if (!last_round) begin
                  state <= SETTLE;
                  cnt_clr <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                  round <= round + 2'd1;
                  votes <= votes + {1'b0, gt};
`endif
               end else begin
                  response[idx] <= bit_res;
`ifdef PUF_MAJORITY_VOTE_EN
                  round <= '0;
                  votes <= '0;
`endif
                  if (idx == IW'(RESP_BITS - 1)) begin
                     state <= DONE;
                     osc_en <= 1'b0;
                     resp_valid <= 1'b1;
                  end else begin
                     state <= SETTLE;
                     cnt_clr <= 1'b1;
                     idx <= idx + IW'(1);
                     {sel_a, sel_b} <= pair(chal, SEL_W'(idx + IW'(1)));
                  end
               end
            end
            DONE: if (resp_ready) begin
               state <= IDLE;
               resp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: scoreboard bench for puf_eval_ctrl with a per-measurement count model.
// Honours PUF_MAJORITY_VOTE_EN to match the DUT build.
module tb_puf_eval_ctrl;
   import puf_pkg::*;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int R = 3;
   localparam int LAT = 553;
`else
   localparam int R = 1;
   localparam int LAT = 185;
`endif
   typedef struct {
      logic [7:0] resp;
      logic       tie;
      int         lat;
   } exp_t;

   logic clk = 1'b0, rst_n, req_valid, req_ready, osc_en, cnt_clr, cnt_gate, resp_valid, resp_ready, tie;
   logic [7:0] challenge, response, cur_ch;
   logic [4:0] sel_a, sel_b;
   logic [15:0] cnt_a, cnt_b;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0, t0 = 0, mc = 0, mode = 0;
   bit done = 0;

   puf_eval_ctrl #(.CNT_W(16), .WINDOW_CYCLES(16), .SETTLE_CYCLES(4), .RESP_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .challenge(challenge),
      .sel_a(sel_a), .sel_b(sel_b), .osc_en(osc_en), .cnt_clr(cnt_clr), .cnt_gate(cnt_gate),
      .cnt_a(cnt_a), .cnt_b(cnt_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .response(response), .tie(tie)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // outcome 1: A>B (MSB set, catches signed compare), 0: A<B, 2: equal
   function automatic logic [31:0] cnt_model(input int md, input int m);
      int i, r, o;
      if (m < 1) return '0;
      i = (m - 1) / R;
      r = (m - 1) % R;
      o = (i % 2 == 0) ? 1 : 0;
      if (md == 1 && i == 2) o = 2;
      if (md == 3) o = (r == 1) ? 0 : 1;
      if (md == 4) o = (r == 0) ? 1 : (r == 1) ? 0 : 2;
      return o == 1 ? {16'h8000, 16'h7FFF} : o == 0 ? {16'h0001, 16'hFFFF} : {16'h1234, 16'h1234};
   endfunction

   task automatic monitor();
      logic rv_p = 0, rdy_p = 1, clr_p = 0;
      logic [2:0] g = '0;
      logic [9:0] p;
      exp_t e;
      int i;
      while (!done) begin
         @(negedge clk);
         if (rdy_p && !req_ready && rst_n) mc = 0;
         if (cnt_clr && !clr_p) mc++;
         {cnt_a, cnt_b} = cnt_model(mode, mc);
         if (osc_en && !cnt_gate && g == 3'b100) begin
            i = (mc - 1) / R;
            p = pair(cur_ch, 5'(i));
            check("sel_a", sel_a, p[9:5]);
            check("sel_b", sel_b, p[4:0]);
            check("sel_distinct", sel_a != sel_b, 1);
            if (cur_ch == 8'h00) begin
               check("sel_a_basic", sel_a, i);
               check("sel_b_basic", sel_b, i ^ 1);
            end
            if (cur_ch == 8'h1F) check("sel_a_wrap", sel_a, (i + 31) % 32);
         end
         if (resp_valid && !rv_p) begin
            if (q.size() == 0) check("unexpected_resp", 1, 0);
            else begin
               e = q.pop_front();
               check("response", response, e.resp);
               check("tie", tie, e.tie);
               check("latency", cyc - t0, e.lat);
            end
         end
         rv_p = resp_valid;
         rdy_p = req_ready;
         clr_p = cnt_clr;
         g = {g[1:0], cnt_gate};
      end
   endtask

   task automatic request(input logic [7:0] ch, input int md, input logic [7:0] er, input logic et, input bit push);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_before_req", req_ready, 1);
      cur_ch = ch;
      mode = md;
      challenge = ch;
      req_valid = 1;
      t0 = cyc;
      if (push) q.push_back('{er, et, LAT});
      @(posedge clk);
      #1 req_valid = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((q.size() != 0 || !req_ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("wait_done_timeout", n < 3000, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 1);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_osc_en"}, osc_en, 0);
      check({tag, "_cnt_clr"}, cnt_clr, 0);
      check({tag, "_cnt_gate"}, cnt_gate, 0);
      check({tag, "_sel_a"}, sel_a, 0);
      check({tag, "_sel_b"}, sel_b, 0);
      check({tag, "_response"}, response, 0);
      check({tag, "_tie"}, tie, 0);
   endtask

   task automatic stimulus();
      int n;
      rst_n = 0;
      req_valid = 0;
      challenge = 0;
      resp_ready = 1;
      cur_ch = 0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1;
      request(8'h00, 0, 8'h55, 1'b0, 1);
      wait_done();
      request(8'hE3, 1, 8'h51, 1'b1, 1);
      wait_done();
      request(8'h1F, 2, 8'h55, 1'b0, 1);
      wait_done();
      resp_ready = 0;
      request(8'h00, 0, 8'h55, 1'b0, 1);
      n = 0;
      while (!resp_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("bp_wait_timeout", n < 3000, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         req_valid = (k == 3);
         check("bp_response", response, 8'h55);
         check("bp_resp_valid", resp_valid, 1);
         check("bp_req_ready", req_ready, 0);
      end
      req_valid = 0;
      resp_ready = 1;
      @(negedge clk);
      check("b2b_req_ready", req_ready, 1);
      check("b2b_resp_valid", resp_valid, 0);
      repeat (4) begin
         @(negedge clk);
         check("ignored_req_osc", osc_en, 0);
      end
      wait_done();
      request(8'h00, 0, 8'h00, 1'b0, 0);
      n = 0;
      while (!(mc == 3 * R + 1 && cnt_gate) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rst_wait_timeout", n < 3000, 1);
      #2 rst_n = 0;
      #1 check_idle_outputs("async_rst");
      @(negedge clk);
      check_idle_outputs("held_rst");
      rst_n = 1;
      request(8'h00, 0, 8'h55, 1'b0, 1);
      wait_done();
`ifdef PUF_MAJORITY_VOTE_EN
      request(8'h00, 3, 8'hFF, 1'b0, 1);
      wait_done();
      request(8'h00, 4, 8'h00, 1'b1, 1);
      wait_done();
`endif
      done = 1;
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencer for the ring-oscillator PUF datapath: one request runs an evaluation of RESP_BITS response bits. For each bit it selects an oscillator pair through the 32:1 selector indices, clears the counters, enables the oscillators, opens a fixed counting window, and compares the two edge counts. It sits between the host-facing request/response handshake and the oscillator bank, selector muxes and edge counters. The counters must deliver clk-synchronized count values.

## Interface
- CNT_W, 16: width of the incoming count values.
- WINDOW_CYCLES, 1024: clk cycles for which the count gate is open per measurement; must be ≥1.
- SETTLE_CYCLES, 4: clk cycles for oscillator enable and counter clear before the window opens; must be ≥1.
- RESP_BITS, 8: response bits per request; must be 1..32.

- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  challenge request.
- req_ready  out  1  high only in IDLE.
- challenge  in  8  captured on accept.
- sel_a  out  5  selector index for counter A.
- sel_b  out  5  selector index for counter B.
- osc_en  out  1  oscillator bank enable.
- cnt_clr  out  1  synchronous clear to both counters.
- cnt_gate  out  1  count-enable to both counters.
- cnt_a  in  CNT_W  synchronized count A.
- cnt_b  in  CNT_W  synchronized count B.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- response  out  RESP_BITS  bit i is the result of pair i.
- tie  out  1  at least one comparison was equal.

## Operation
- States are IDLE, SETTLE, MEASURE, HOLD, COMPARE and DONE.
- **Reset:** state goes to IDLE and all outputs go to 0, except req_ready, which is 1.
- **IDLE:**
  - Moves to SETTLE on req_valid && req_ready.
  - On that transition: challenge is latched, bit index i is set to 0, response and tie are cleared.
- **Pair selection:**
  - sel_a = (challenge[4:0] + i) mod 32.
  - sel_b = sel_a ^ {challenge[7:5], 2'b01}.
  - The XOR term is never zero, so sel_a ≠ sel_b always.
  - Both outputs are held constant from SETTLE through COMPARE.
- **SETTLE:** lasts SETTLE_CYCLES cycles with osc_en=1, cnt_clr=1, cnt_gate=0.
- **MEASURE:** lasts WINDOW_CYCLES cycles with osc_en=1, cnt_clr=0, cnt_gate=1.
- **HOLD:** lasts SYNC_LAT=2 cycles with cnt_gate=0 and osc_en=1, so the counter synchronizers can settle.
- **COMPARE:** lasts 1 cycle.
  - Computes bit = (cnt_a > cnt_b) as an unsigned compare and writes it into response[i].
  - If cnt_a == cnt_b, the bit is 0 and tie is set (sticky).
  - If i < RESP_BITS-1: i increments and the state returns to SETTLE. Otherwise the state moves to DONE.
- **DONE:**
  - osc_en=0 and resp_valid=1.
  - response and tie are held stable until resp_ready is sampled high, then the state returns to IDLE.
  - resp_ready is ignored outside DONE.
- **req_valid during evaluation:** ignored, since req_ready=0.
- **Reset mid-evaluation:** immediate abort; no partial response is produced.

## Timing
- Define T0 as the accept cycle. SETTLE starts at T0+1.
- Per bit: P = SETTLE_CYCLES + WINDOW_CYCLES + 3 cycles.
- resp_valid rises at T0 + 1 + RESP_BITS·P.
- Back-to-back operation: req_ready returns to 1 in the cycle after the DONE handshake.
- All outputs are registered.
- The phase timer is a down-counter of width $clog2(max(WINDOW_CYCLES, SETTLE_CYCLES)+1).

## Configuration
- **PUF_MAJORITY_VOTE_EN defined:**
  - Each bit is measured in 3 consecutive rounds, each a full SETTLE→COMPARE sequence on the same pair.
  - Final bit = majority of the 3 comparison results; an equal count counts as a 0 vote.
  - tie is set if any round was equal.
  - Per-bit time becomes 3·P.
- **Undefined:** single measurement per bit, as described in Operation.

## Structure
- **Shared package puf_pkg:**
  - State enum.
  - SYNC_LAT = 2.
  - Selector width 5 and oscillator count 32.
  - Pair-derivation function (challenge, i) → {sel_a, sel_b}, reused by the bench model.
- **One sub-module, puf_phase_timer:** loadable down-counter with load, value and zero flag, driven by the FSM for the SETTLE, MEASURE and HOLD durations.

## Test plan
All scenarios use WINDOW_CYCLES=16, SETTLE_CYCLES=4, RESP_BITS=8, so P=23.
- **Basic evaluation:**
  - Stimulus: challenge 0x00; count model gives A > B for even i and A < B for odd i.
  - Response: response=0x55, tie=0, resp_valid at T0+185.
  - Also check: sel_a=i and sel_b=i^1 at every COMPARE.
- **Tie flag:** challenge 0xE3 with equal counts at i=2 → response bit 2 = 0, tie=1, sel_b = sel_a^5'b11101.
- **Wrap-around:** challenge 0x1F → sel_a sequence is 31,0,1,…,6, and sel_a ≠ sel_b at every step.
- **Response backpressure:** resp_ready held low 10 cycles → response stable, resp_valid stays 1, req_ready=0; a req_valid pulse in this period is ignored.
- **Reset mid-evaluation:** rst_n low during MEASURE of i=3 → all outputs 0 and req_ready=1 asynchronously; a new request is accepted after release with correct timing.
- **PUF_MAJORITY_VOTE_EN:**
  - Stimulus: rounds per bit give results 1,0,1.
  - Response: bit = 1; resp_valid at T0+1+8·69.
  - Second case: results 1,0,tie → bit = 0 and tie=1.
